// File: rtl/tcm_pkg.sv
// Shared definitions for the tightly-coupled memory controller: width
// derivations, the address decode helper, read-latency limits and the
// arbitration priority encoding.
package tcm_pkg;

  localparam int unsigned TCM_RD_LAT_MIN = 1;
  localparam int unsigned TCM_RD_LAT_MAX = 2;

  // Which side wins the next same-bank collision.
  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } tcm_prio_e;

  // Decoded address; wide fields so any ADDR_W up to 64 fits.
  typedef struct packed {
    logic [63:0] word;
    logic [63:0] bank;
    logic [63:0] row;
  } tcm_dec_t;

  function automatic int unsigned tcm_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned tcm_bank_w(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int unsigned tcm_row_w(input int unsigned depth_words,
                                            input int unsigned num_banks);
    int unsigned rows;
    rows = depth_words / num_banks;
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic bit tcm_rd_lat_ok(input int unsigned rd_lat);
    return (rd_lat >= TCM_RD_LAT_MIN) && (rd_lat <= TCM_RD_LAT_MAX);
  endfunction

  // Byte address -> word, bank (low word bits) and row (remaining word bits).
  function automatic tcm_dec_t tcm_decode(input logic [63:0] addr,
                                          input int unsigned off_w,
                                          input int unsigned bank_w);
    tcm_dec_t d;
    d.word = addr >> off_w;
    d.bank = d.word & ((64'd1 << bank_w) - 64'd1);
    d.row  = d.word >> bank_w;
    return d;
  endfunction

endpackage

// File: rtl/tcm_bank.sv
// One TCM bank: synchronous single-port RAM with byte-lane write enables
// and a registered read port. The RAM array itself is never reset; only
// the read register is.
module tcm_bank
  import tcm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROWS   = 2048,
  parameter int unsigned ROW_W  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ROW_W-1:0]    row,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] rd_word;

  // Each byte lane is its own array so partial writes need no read-modify-write.
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    logic [7:0] lane [ROWS];

    // Byte-lane write on accept with this lane enabled
    always_ff @(posedge clk) begin
      if (we && be[i]) begin
        lane[row] <= wdata[i*8 +: 8];
      end
    end

    assign rd_word[i*8 +: 8] = lane[row];
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_word;
    end
  end

endmodule

// File: rtl/tcm_ctrl.sv
// Tightly-coupled memory controller: valid/ready write and read ports onto
// NUM_BANKS word-interleaved banks, with fair same-bank arbitration and a
// 1- or 2-cycle read response pipeline.
// Optional feature macro: TCM_ERR_EN (out-of-range detection and error
// reporting); without it addresses wrap and the error outputs stay 0.
module tcm_ctrl
  import tcm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_err,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_rsp_valid,
  output logic [DATA_W-1:0]   rd_rsp_data,
  output logic                rd_rsp_err
);

  localparam int unsigned OFF_W  = tcm_off_w(DATA_W);
  localparam int unsigned BANK_W = tcm_bank_w(NUM_BANKS);
  localparam int unsigned ROW_W  = tcm_row_w(DEPTH_WORDS, NUM_BANKS);
  localparam int unsigned ROWS   = DEPTH_WORDS / NUM_BANKS;
  localparam int unsigned SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam bit          LAT_OK = tcm_rd_lat_ok(RD_LAT);

  // Read latency outside the supported range is a configuration error
  always_comb begin : lat_check
    assert (LAT_OK) else $error("tcm_ctrl: RD_LAT must be 1 or 2");
  end

  tcm_dec_t         wr_dec;
  tcm_dec_t         rd_dec;
  logic [SEL_W-1:0] wr_bank;
  logic [SEL_W-1:0] rd_bank;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_row;
  logic             wr_oor;
  logic             rd_oor;
  logic             unused_dec;

  // Address decode for both ports; row truncation gives the wrap behaviour
  always_comb begin
    wr_dec  = tcm_decode(64'(wr_addr), OFF_W, BANK_W);
    rd_dec  = tcm_decode(64'(rd_addr), OFF_W, BANK_W);
    wr_bank = wr_dec.bank[SEL_W-1:0];
    rd_bank = rd_dec.bank[SEL_W-1:0];
    wr_row  = wr_dec.row[ROW_W-1:0];
    rd_row  = rd_dec.row[ROW_W-1:0];
`ifdef TCM_ERR_EN
    wr_oor  = wr_dec.word >= 64'(DEPTH_WORDS);
    rd_oor  = rd_dec.word >= 64'(DEPTH_WORDS);
`else
    wr_oor  = 1'b0;
    rd_oor  = 1'b0;
`endif
  end

  assign unused_dec = ^{wr_dec, rd_dec};

  tcm_prio_e rd_prio;
  logic      conflict;
  logic      wr_fire;
  logic      rd_fire;

  assign conflict = wr_valid && rd_valid && (wr_bank == rd_bank);
  assign wr_ready = !conflict || (rd_prio == PRIO_WR);
  assign rd_ready = !conflict || (rd_prio == PRIO_RD);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  // Fairness bit: alternates on back-to-back conflicts, cleared otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prio <= PRIO_WR;
    end else if (conflict) begin
      rd_prio <= (rd_prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end else begin
      rd_prio <= PRIO_WR;
    end
  end

  // Out-of-range write indication, one cycle after the accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_fire && wr_oor;
    end
  end

  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS-1:0] bank_re;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  // Arbitration guarantees a bank never sees a read and a write together,
  // so each bank's single address port is muxed by its write enable.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ROW_W-1:0] row;

    assign bank_we[b] = wr_fire && !wr_oor && (wr_bank == SEL_W'(b));
    assign bank_re[b] = rd_fire && !rd_oor && (rd_bank == SEL_W'(b));
    assign row        = bank_we[b] ? wr_row : rd_row;

    tcm_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[b]),
      .re    (bank_re[b]),
      .be    (wr_be),
      .row   (row),
      .wdata (wr_data),
      .rdata (bank_rdata[b])
    );
  end

  logic              s1_valid;
  logic [SEL_W-1:0]  s1_bank;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  // First response stage, aligned with the bank read registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_bank <= rd_bank;
        s1_err  <= rd_oor;
      end
    end
  end

  // Bank select and error flag only change on a read, so data holds between responses.
  assign s1_data = s1_err ? '0 : bank_rdata[s1_bank];

  if (RD_LAT >= 2) begin : g_lat2
    logic              s2_valid;
    logic              s2_err;
    logic [DATA_W-1:0] s2_data;

    // Extra output register stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_err  <= s1_err;
          s2_data <= s1_data;
        end
      end
    end

    assign rd_rsp_valid = s2_valid;
    assign rd_rsp_data  = s2_data;
    assign rd_rsp_err   = s2_err;
  end else begin : g_lat1
    assign rd_rsp_valid = s1_valid;
    assign rd_rsp_data  = s1_data;
    assign rd_rsp_err   = s1_err;
  end

endmodule
